// File: rtl/pa_defines.sv
// Global width defaults shared by the coprocessor-interface blocks.
package pa_defines;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned FLEN       = 32;

endpackage

// File: rtl/pa_rvfpm.sv
// Types shared by the XIF memory responder: request/result records, the
// responder FSM state encoding, the access-size encoding and the
// misalignment helper.
package pa_rvfpm;

  typedef struct packed {
    logic [pa_defines::X_ID_WIDTH-1:0] id;
    logic [pa_defines::XLEN-1:0]       addr;
    logic [pa_defines::FLEN-1:0]       wdata;
    logic                              we;
    logic [2:0]                        size;
    logic [3:0]                        be;
  } x_mem_req_t;

  typedef struct packed {
    logic [pa_defines::X_ID_WIDTH-1:0] id;
    logic [pa_defines::FLEN-1:0]       rdata;
    logic                              err;
    logic                              dbg;
  } x_mem_result_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusReq,
    StWaitRsp,
    StResult
  } xmr_state_e;

  // Access size encoding (log2 of the byte count); anything above word is illegal.
  localparam logic [2:0] MemSizeByte = 3'd0;
  localparam logic [2:0] MemSizeHalf = 3'd1;
  localparam logic [2:0] MemSizeWord = 3'd2;

  function automatic logic mem_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == MemSizeHalf) begin
      mis = addr_lo[0];
    end else if (size == MemSizeWord) begin
      mis = (addr_lo != 2'b00);
    end else if (size > MemSizeWord) begin
      mis = 1'b1;
    end
    return mis;
  endfunction

endpackage

// File: rtl/xif_timeout_cnt.sv
// Response timeout counter.
//   ck, rst  : clock, asynchronous active-low reset
//   clear    : force the count to zero (has priority)
//   enable   : count one cycle
//   expired  : high in the TIMEOUT_CYCLES-th enabled cycle after a clear
module xif_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic ck,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xif_mem_responder.sv
// XIF memory-channel responder: accepts one coprocessor memory request at a
// time, performs it on a simple req/gnt/rvalid data bus and returns a
// single-cycle result strobe. Misaligned requests are answered with an error
// without touching the bus; a bus that never responds is timed out.
//   ck, rst                 : clock, asynchronous active-low reset
//   mem_valid/mem_ready     : request handshake, mem_req_* request fields
//   mem_result_*            : result strobe and fields (no back-pressure)
//   bus_req, bus_*          : data-bus request, held until bus_gnt
//   bus_rvalid/rdata/err    : data-bus response
// All outputs are registers; data fields read 0 while their strobe is low.
module xif_mem_responder
  import pa_rvfpm::*;
#(
  parameter int unsigned X_ID_WIDTH     = pa_defines::X_ID_WIDTH,
  parameter int unsigned XLEN           = pa_defines::XLEN,
  parameter int unsigned X_MEM_WIDTH    = pa_defines::FLEN,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [X_ID_WIDTH-1:0]  mem_req_id,
  input  logic [XLEN-1:0]        mem_req_addr,
  input  logic [X_MEM_WIDTH-1:0] mem_req_wdata,
  input  logic                   mem_req_we,
  input  logic [2:0]             mem_req_size,
  input  logic [3:0]             mem_req_be,
  output logic                   mem_result_valid,
  output logic [X_ID_WIDTH-1:0]  mem_result_id,
  output logic [X_MEM_WIDTH-1:0] mem_result_rdata,
  output logic                   mem_result_err,
  output logic                   mem_result_dbg,
  output logic                   bus_req,
  output logic [XLEN-1:0]        bus_addr,
  output logic                   bus_we,
  output logic [3:0]             bus_be,
  output logic [X_MEM_WIDTH-1:0] bus_wdata,
  input  logic                   bus_gnt,
  input  logic                   bus_rvalid,
  input  logic [X_MEM_WIDTH-1:0] bus_rdata,
  input  logic                   bus_err
);

  xmr_state_e state_q, state_d;

  // Latched request
  logic [X_ID_WIDTH-1:0]  id_q, id_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [X_MEM_WIDTH-1:0] wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [2:0]             size_q, size_d;
  logic [3:0]             be_q, be_d;

  // Next values of the registered outputs
  logic                   ready_d, breq_d, rvalid_d, err_d;
  logic [XLEN-1:0]        baddr_d;
  logic                   bwe_d;
  logic [3:0]             bbe_d;
  logic [X_MEM_WIDTH-1:0] bwdata_d, rdata_d;
  logic [X_ID_WIDTH-1:0]  rid_d;

  logic wait_active, tmo_expired;

  assign wait_active = (state_q == StWaitRsp);

  // Counts only while waiting; held at zero otherwise so it restarts on entry.
  xif_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .ck      (ck),
    .rst     (rst),
    .clear   (!wait_active),
    .enable  (wait_active),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    be_d    = be_q;
    rdata_d = '0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_valid && mem_ready) begin
          id_d    = mem_req_id;
          addr_d  = mem_req_addr;
          wdata_d = mem_req_wdata;
          we_d    = mem_req_we;
          size_d  = mem_req_size;
          be_d    = mem_req_be;
          state_d = StBusReq;
        end
      end
      StBusReq: begin
        // A misaligned request never raises bus_req here and retires with an error.
        if (mem_misaligned(size_q, addr_q[1:0])) begin
          state_d = StResult;
          err_d   = 1'b1;
        end else if (bus_gnt) begin
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        // A response in the final counted cycle still wins over the timeout.
        if (bus_rvalid) begin
          state_d = StResult;
          err_d   = bus_err;
          rdata_d = we_q ? '0 : bus_rdata;
        end else if (tmo_expired) begin
          state_d = StResult;
          err_d   = 1'b1;
        end
      end
      StResult: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d  = (state_d == StIdle);
    breq_d   = (state_d == StBusReq) && !mem_misaligned(size_d, addr_d[1:0]);
    baddr_d  = breq_d ? addr_d  : '0;
    bwe_d    = breq_d ? we_d    : 1'b0;
    bbe_d    = breq_d ? be_d    : '0;
    bwdata_d = breq_d ? wdata_d : '0;
    rvalid_d = (state_d == StResult);
    rid_d    = rvalid_d ? id_d : '0;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      id_q             <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      we_q             <= 1'b0;
      size_q           <= '0;
      be_q             <= '0;
      mem_ready        <= 1'b0;
      mem_result_valid <= 1'b0;
      mem_result_id    <= '0;
      mem_result_rdata <= '0;
      mem_result_err   <= 1'b0;
      mem_result_dbg   <= 1'b0;
      bus_req          <= 1'b0;
      bus_addr         <= '0;
      bus_we           <= 1'b0;
      bus_be           <= '0;
      bus_wdata        <= '0;
    end else begin
      state_q          <= state_d;
      id_q             <= id_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      we_q             <= we_d;
      size_q           <= size_d;
      be_q             <= be_d;
      mem_ready        <= ready_d;
      mem_result_valid <= rvalid_d;
      mem_result_id    <= rid_d;
      mem_result_rdata <= rdata_d;
      mem_result_err   <= err_d;
      mem_result_dbg   <= 1'b0;
      bus_req          <= breq_d;
      bus_addr         <= baddr_d;
      bus_we           <= bwe_d;
      bus_be           <= bbe_d;
      bus_wdata        <= bwdata_d;
    end
  end

endmodule

// File: tb/tb_xif_mem_responder.sv
module tb_xif_mem_responder;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_req_id = '0;
  logic [31:0] mem_req_addr = '0;
  logic [31:0] mem_req_wdata = '0;
  logic        mem_req_we = 1'b0;
  logic [2:0]  mem_req_size = '0;
  logic [3:0]  mem_req_be = '0;
  logic        mem_result_valid;
  logic [3:0]  mem_result_id;
  logic [31:0] mem_result_rdata;
  logic        mem_result_err;
  logic        mem_result_dbg;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  xif_mem_responder dut (
    .ck               (ck),
    .rst              (rst),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_req_id       (mem_req_id),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_req_we       (mem_req_we),
    .mem_req_size     (mem_req_size),
    .mem_req_be       (mem_req_be),
    .mem_result_valid (mem_result_valid),
    .mem_result_id    (mem_result_id),
    .mem_result_rdata (mem_result_rdata),
    .mem_result_err   (mem_result_err),
    .mem_result_dbg   (mem_result_dbg),
    .bus_req          (bus_req),
    .bus_addr         (bus_addr),
    .bus_we           (bus_we),
    .bus_be           (bus_be),
    .bus_wdata        (bus_wdata),
    .bus_gnt          (bus_gnt),
    .bus_rvalid       (bus_rvalid),
    .bus_rdata        (bus_rdata),
    .bus_err          (bus_err)
  );

  initial forever #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: expected result fields and the cycle it must appear in.
  typedef struct {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Result monitor
  always @(negedge ck) begin
    if (mem_result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(mem_result_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("res_id", 64'(mem_result_id), 64'(mon_e.id));
        check("res_rdata", 64'(mem_result_rdata), 64'(mon_e.rdata));
        check("res_err", 64'(mem_result_err), 64'(mon_e.err));
        check("res_dbg", 64'(mem_result_dbg), 64'd0);
        check("res_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end else begin
      check("res_idle_zero", 64'({mem_result_id, mem_result_rdata, mem_result_err,
                                  mem_result_dbg}), 64'd0);
      if (sb.size() > 0 && sb[0].at < cyc) begin
        mon_e = sb.pop_front();
        check("res_missing", 64'(mem_result_valid), 64'd1);
      end
    end
  end

  // Bus model: grants in the first bus_req cycle, answers rsp_wait cycles later.
  int          rsp_wait = 1;
  bit          rsp_never = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  int          pend = 0;
  int          bus_req_cnt = 0;
  logic [31:0] exp_baddr = '0;
  logic        exp_bwe = 1'b0;
  logic [3:0]  exp_bbe = '0;
  logic [31:0] exp_bwdata = '0;

  always @(negedge ck) begin
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !rsp_never) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rsp_data;
        bus_err    = rsp_err;
      end
    end
    if (bus_req) begin
      bus_req_cnt++;
      check("bus_addr", 64'(bus_addr), 64'(exp_baddr));
      check("bus_we", 64'(bus_we), 64'(exp_bwe));
      check("bus_be", 64'(bus_be), 64'(exp_bbe));
      check("bus_wdata", 64'(bus_wdata), 64'(exp_bwdata));
      bus_gnt = 1'b1;
      pend    = rsp_wait;
    end else begin
      check("bus_idle_zero", 64'({bus_addr, bus_we, bus_be, bus_wdata}), 64'd0);
    end
  end

  task automatic set_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
    exp_baddr  = a;
    exp_bwe    = we;
    exp_bbe    = be;
    exp_bwdata = wd;
  endtask

  // Called just after a negedge; returns at the negedge following the handshake.
  task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic [2:0] size, input logic [3:0] be,
                       input bit push, input logic [31:0] e_rdata, input logic e_err,
                       input int lat, input bit hold);
    mem_req_id    = id;
    mem_req_addr  = addr;
    mem_req_wdata = wdata;
    mem_req_we    = we;
    mem_req_size  = size;
    mem_req_be    = be;
    mem_valid     = 1'b1;
    for (int i = 0; i < 200 && !mem_ready; i++) @(negedge ck);
    if (!mem_ready) begin
      check("handshake_timeout", 64'(mem_ready), 64'd1);
    end else if (push) begin
      sb.push_back('{id: id, rdata: e_rdata, err: e_err, at: cyc + lat});
    end
    @(negedge ck);
    check("ready_drop", 64'(mem_ready), 64'd0);
    if (!hold) mem_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge ck);
    if (sb.size() != 0) check("drain", 64'(sb.size()), 64'd0);
    @(negedge ck);
  endtask

  int cnt0;

  initial begin
    // Reset: all outputs low, mem_ready in the first cycle after release
    repeat (3) @(negedge ck);
    check("rst_outputs", 64'({mem_ready, bus_req, mem_result_valid}), 64'd0);
    rst = 1'b1;
    check("ready_at_release", 64'(mem_ready), 64'd0);
    @(negedge ck);
    check("ready_after_rst", 64'(mem_ready), 64'd1);

    // Aligned word load, gnt same cycle, rvalid next -> result at N+3
    set_bus(32'h100, 1'b0, 4'hF, 32'h0);
    rsp_data = 32'hDEADBEEF;
    issue(4'd3, 32'h100, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1'b0);
    drain();

    // Misaligned word/half and illegal size: no bus access, err at N+2
    cnt0 = bus_req_cnt;
    issue(4'd5, 32'h102, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'h0, 1'b1, 2, 1'b0);
    issue(4'd7, 32'h101, 32'h0, 1'b0, 3'd1, 4'h3, 1'b1, 32'h0, 1'b1, 2, 1'b0);
    issue(4'd8, 32'h100, 32'h0, 1'b0, 3'd3, 4'hF, 1'b1, 32'h0, 1'b1, 2, 1'b0);
    drain();
    check("no_bus_misaligned", 64'(bus_req_cnt), 64'(cnt0));

    // Aligned halfword at offset 2
    set_bus(32'h102, 1'b0, 4'hC, 32'h0);
    rsp_data = 32'h0000ABCD;
    issue(4'd9, 32'h102, 32'h0, 1'b0, 3'd1, 4'hC, 1'b1, 32'h0000ABCD, 1'b0, 3, 1'b0);
    drain();

    // Timeout: WAIT_RSP entered at N+2, 16 cycles, result at N+18
    rsp_never = 1'b1;
    set_bus(32'h104, 1'b0, 4'hF, 32'h0);
    issue(4'd10, 32'h104, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'h0, 1'b1, 18, 1'b0);
    drain();
    rsp_never = 1'b0;

    // Response in the last allowed cycle is accepted (same result cycle)
    rsp_wait = 16;
    rsp_data = 32'h13579BDF;
    set_bus(32'h108, 1'b0, 4'hF, 32'h0);
    issue(4'd11, 32'h108, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'h13579BDF, 1'b0, 18, 1'b0);
    drain();
    rsp_wait = 1;

    // Bus error on a load propagates with the captured data
    rsp_err  = 1'b1;
    rsp_data = 32'h00000055;
    set_bus(32'h10C, 1'b0, 4'hF, 32'h0);
    issue(4'd12, 32'h10C, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'h00000055, 1'b1, 3, 1'b0);
    drain();
    rsp_err = 1'b0;

    // Back-pressure: mem_valid held, second request waits for IDLE, in order
    rsp_data = 32'hCAFEF00D;
    set_bus(32'h110, 1'b0, 4'hF, 32'h0);
    issue(4'd4, 32'h110, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 3, 1'b1);
    issue(4'd6, 32'h110, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 3, 1'b0);
    drain();

    // Store: bus sees we/be/wdata, result rdata forced to 0
    rsp_data = 32'hFFFFFFFF;
    set_bus(32'h200, 1'b1, 4'b0011, 32'h1234);
    issue(4'd1, 32'h200, 32'h1234, 1'b1, 3'd2, 4'b0011, 1'b1, 32'h0, 1'b0, 3, 1'b0);
    drain();

    // Reset during WAIT_RSP, late rvalid afterwards: no result at all
    rsp_wait = 5;
    rsp_data = 32'h0BADF00D;
    set_bus(32'h300, 1'b0, 4'hF, 32'h0);
    issue(4'd13, 32'h300, 32'h0, 1'b0, 3'd2, 4'hF, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    @(negedge ck);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({mem_ready, bus_req, mem_result_valid}), 64'd0);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    check("ready_after_rst2", 64'(mem_ready), 64'd1);
    repeat (8) @(negedge ck);
    rsp_wait = 1;

    // Recovery transaction after the abandoned one
    rsp_data = 32'h600DCAFE;
    set_bus(32'h400, 1'b0, 4'hF, 32'h0);
    issue(4'd14, 32'h400, 32'h0, 1'b0, 3'd2, 4'hF, 1'b1, 32'h600DCAFE, 1'b0, 3, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/xif_mem_responder.md
XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default pa_defines::X_ID_WIDTH, meaning the transaction ID width.
REQ-002 SHALL have parameter XLEN, default pa_defines::XLEN, meaning the address width.
REQ-003 SHALL have parameter X_MEM_WIDTH, default pa_defines::FLEN, meaning the data width (32).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles from bus grant to bus response.
REQ-005 Ports: ck  in  1  clock; the block uses one clock, posedge.
REQ-006 Ports: rst  in  1  asynchronous reset, active-low.
REQ-007 Ports: mem_valid  in  1  coprocessor memory request valid.
REQ-008 Ports: mem_ready  out  1  request accepted this cycle when mem_valid is also 1.
REQ-009 Ports: mem_req_id, mem_req_addr, mem_req_wdata, mem_req_we, mem_req_size, mem_req_be  in  X_ID_WIDTH/XLEN/X_MEM_WIDTH/1/3/4  request fields.
REQ-010 Ports: mem_result_valid  out  1  one-cycle result strobe (no ready; XIF result channel).
REQ-011 Ports: mem_result_id, mem_result_rdata, mem_result_err, mem_result_dbg  out  X_ID_WIDTH/X_MEM_WIDTH/1/1  result fields.
REQ-012 Ports: bus_req, bus_addr, bus_we, bus_be, bus_wdata  out  1/XLEN/1/4/X_MEM_WIDTH  data-bus request.
REQ-013 Ports: bus_gnt  in  1  bus accepted the request.
REQ-014 Ports: bus_rvalid, bus_rdata, bus_err  in  1/X_MEM_WIDTH/1  bus response.

Function
REQ-015 SHALL implement FSM states IDLE, BUS_REQ, WAIT_RSP, RESULT; at most one transaction outstanding.
REQ-016 mem_ready SHALL be 1 only in IDLE; a handshake (mem_valid && mem_ready) SHALL latch id, addr, wdata, we, size, be.
REQ-017 After a handshake, an aligned request SHALL move to BUS_REQ; a misaligned one (size 1 with addr[0]!=0, size 2 with addr[1:0]!=0, or size>2) SHALL move directly to RESULT with err=1 and no bus access.
REQ-018 In BUS_REQ, bus_req SHALL be 1 with the latched fields, held stable until bus_gnt; on bus_gnt the FSM SHALL move to WAIT_RSP.
REQ-019 In WAIT_RSP, a cycle counter SHALL start at 0 on entry and increment each cycle; on bus_rvalid the FSM SHALL capture rdata/err and go to RESULT.
REQ-020 If the counter reaches TIMEOUT_CYCLES without bus_rvalid, the FSM SHALL go to RESULT with err=1 and rdata=0.
REQ-021 RESULT SHALL last exactly one cycle: mem_result_valid=1 with the latched id; then IDLE.
REQ-022 For stores (we=1), mem_result_rdata SHALL be 0.
REQ-023 mem_result_dbg SHALL always be 0.
REQ-024 Minimum latency SHALL be handshake at cycle N, bus_req at N+1, gnt at N+1, rvalid at N+2, mem_result_valid at N+3.
REQ-025 Simultaneous bus_gnt and bus_rvalid in the same cycle SHALL NOT be expected; bus_rvalid outside WAIT_RSP SHALL be ignored.
REQ-026 All outputs SHALL be registered; fields other than the valid/ready signals SHALL be 0 whenever their valid signal is 0.

Reset
REQ-027 Reset SHALL force IDLE and clear the counter and all latched fields.
REQ-028 During reset, all outputs SHALL be 0; mem_ready SHALL rise in the first cycle after rst deasserts.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no mem_result_valid; a late bus_rvalid after reset SHALL be ignored.

Structure
REQ-030 The state enum and the misalignment-size encoding SHALL be placed in package pa_rvfpm, next to x_mem_req_t/x_mem_result_t.
REQ-031 The timeout counter SHALL be a sub-module, xif_timeout_cnt (inputs: clear, enable; output: expired).

Verification
REQ-032 Aligned load: addr 0x100, size 2, id 3; gnt same cycle, rvalid next with rdata 0xDEADBEEF -> mem_result_valid at N+3, id 3, rdata 0xDEADBEEF, err 0.
REQ-033 Misaligned: addr 0x102, size 2, id 5 -> bus_req never asserts; result at N+2 with id 5, err 1.
REQ-034 Timeout: gnt given, rvalid never -> result after TIMEOUT_CYCLES, err 1, rdata 0; next request accepted.
REQ-035 Back-pressure: mem_valid held through a transaction -> mem_ready 0 until IDLE; second request with id 6 returns id 6 in order.
REQ-036 Store: we 1, be 4'b0011, wdata 0x1234 -> bus_we 1, bus_be 0011; result rdata 0.
REQ-037 Reset in WAIT_RSP, then rvalid -> no mem_result_valid; mem_ready 1 one cycle after rst deasserts.
